// File: rtl/commit_trace_streamer.sv
// Commit-bus trace sink: records writeback events in a FIFO and streams them as 32-bit words.
// Optional store tracing is compiled in by defining TRACE_MEM_EN.
module commit_trace_streamer #(
   parameter int DEPTH   = 8,
   parameter int SKIP_R0 = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trace_en,
   input  logic [31:0] pc,
   input  logic        ct_rf_wen,
   input  logic [4:0]  rf_addr_w,
   input  logic [31:0] rf_data_w,
   input  logic        ct_mem_wen,
   input  logic [31:0] alu_res,
   input  logic [31:0] rf_data_r2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic [15:0] drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Store records are recognised by header type bit 31, so no separate kind flag is kept.
   typedef struct packed {
      logic [31:0] hdr;
      logic [31:0] pc;
      logic [31:0] adr;
      logic [31:0] dat;
   } rec_t;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_PC, S_ADR, S_DAT} state_t;

   state_t        state_q, state_d;
   rec_t          mem_q [DEPTH];
   rec_t          hold_q;
   rec_t          rec_new;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [7:0]    seq_q;
   logic [15:0]   pend_q, pend_d;
   logic [15:0]   drop_q, drop_d;
   logic          rf_ev, st_req, want_push, push, pop;
   logic          fifo_empty, fifo_full;
   logic [1:0]    drop_inc;
   logic [16:0]   drop_sum, pend_sum;

   assign rf_ev = trace_en & ct_rf_wen & ~((SKIP_R0 != 0) & (rf_addr_w == 5'd0));

`ifdef TRACE_MEM_EN
   assign st_req = trace_en & ct_mem_wen;
`else
   logic unused_store_bus;
   assign st_req           = 1'b0;
   assign unused_store_bus = ^{ct_mem_wen, alu_res, rf_data_r2};
`endif

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign want_push  = rf_ev | st_req;
   assign push       = want_push & (~fifo_full | pop);

   // A store colliding with an RF write is lost; a full FIFO loses the event as well.
   assign drop_inc = {1'b0, want_push & ~push} + {1'b0, rf_ev & st_req};
   assign drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
   assign pend_sum = {1'b0, (push ? 16'd0 : pend_q)} + {15'd0, drop_inc};
   assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   assign pend_d   = pend_sum[16] ? 16'hFFFF : pend_sum[15:0];

   always_comb begin
      rec_new.hdr = {(rf_ev ? 2'b01 : 2'b10), (pend_q != 16'd0), (rf_ev ? rf_addr_w : 5'd0), seq_q, pend_q};
      rec_new.pc  = pc;
`ifdef TRACE_MEM_EN
      rec_new.adr = alu_res;
      rec_new.dat = rf_ev ? rf_data_w : rf_data_r2;
`else
      rec_new.adr = 32'd0;
      rec_new.dat = rf_data_w;
`endif
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_HDR;
            end
         end
         S_HDR: if (out_ready) state_d = S_PC;
         S_PC: begin
            if (out_ready) begin
`ifdef TRACE_MEM_EN
               state_d = hold_q.hdr[31] ? S_ADR : S_DAT;
`else
               state_d = S_DAT;
`endif
            end
         end
         S_ADR: if (out_ready) state_d = S_DAT;
         S_DAT: begin
            if (out_ready) begin
               pop     = ~fifo_empty;
               state_d = fifo_empty ? S_IDLE : S_HDR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_data = 32'd0;
      case (state_q)
         S_HDR:   out_data = hold_q.hdr;
         S_PC:    out_data = hold_q.pc;
         S_ADR:   out_data = hold_q.adr;
         S_DAT:   out_data = hold_q.dat;
         default: out_data = 32'd0;
      endcase
   end

   assign out_valid = (state_q != S_IDLE);
   assign out_last  = (state_q == S_DAT);
   assign drop_cnt  = drop_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         seq_q    <= 8'd0;
         pend_q   <= 16'd0;
         drop_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
         if (push) seq_q <= seq_q + 8'd1;
         pend_q <= pend_d;
         drop_q <= drop_d;
      end
   end

   // Record storage stays unreset so it maps onto block RAM; the pop read is registered into hold_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rec_new;
      if (pop)  hold_q <= mem_q[rd_ptr_q];
   end
endmodule

// File: tb/tb_commit_trace_streamer.sv
// Self-checking bench for commit_trace_streamer: queue-based record model plus directed scenarios.
module tb_commit_trace_streamer;
   localparam int DEPTH   = 8;
   localparam int SKIP_R0 = 1;
`ifdef TRACE_MEM_EN
   localparam bit MEM = 1'b1;
`else
   localparam bit MEM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trace_en = 1'b0;
   logic [31:0] pc = '0;
   logic        ct_rf_wen = 1'b0;
   logic [4:0]  rf_addr_w = '0;
   logic [31:0] rf_data_w = '0;
   logic        ct_mem_wen = 1'b0;
   logic [31:0] alu_res = '0;
   logic [31:0] rf_data_r2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   commit_trace_streamer #(.DEPTH(DEPTH), .SKIP_R0(SKIP_R0)) dut (
      .clk(clk), .rst(rst), .trace_en(trace_en), .pc(pc), .ct_rf_wen(ct_rf_wen),
      .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w), .ct_mem_wen(ct_mem_wen),
      .alu_res(alu_res), .rf_data_r2(rf_data_r2), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .drop_cnt(drop_cnt)
   );

   typedef struct packed {
      logic [3:0][31:0] w;
      logic [2:0]       len;
   } rec_t;

   rec_t        m_fifo[$];
   rec_t        m_cur;
   bit          m_act = 1'b0;
   int          m_idx = 0;
   logic [7:0]  m_seq = 8'd0;
   logic [15:0] m_pend = 16'd0;
   logic [15:0] m_drops = 16'd0;
   logic [31:0] obs[$];
   int          ntests = 0;
   int          nfail = 0;

   // One clock: drive inputs, log any accepted word, advance the model at the edge.
   task automatic cycle(input bit rfw, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p,
                        input bit sw, input logic [31:0] sa, input logic [31:0] sd,
                        input bit en, input bit rdy);
      bit   hs, fin, popm, rf, st;
      int   nd;
      rec_t r, nxt;
      ct_rf_wen = rfw; rf_addr_w = a; rf_data_w = d; pc = p;
      ct_mem_wen = sw; alu_res = sa; rf_data_r2 = sd; trace_en = en; out_ready = rdy;
      if (rst && out_valid && rdy) obs.push_back(out_data);
      @(posedge clk);
      if (!rst) begin
         m_fifo.delete(); m_act = 1'b0; m_idx = 0; m_seq = 8'd0; m_pend = 16'd0; m_drops = 16'd0;
      end else begin
         hs   = m_act && rdy;
         fin  = hs && (m_idx == int'(m_cur.len) - 1);
         popm = (!m_act || fin) && (m_fifo.size() > 0);
         if (popm) nxt = m_fifo.pop_front();
         rf = en && rfw && !((SKIP_R0 != 0) && (a == 5'd0));
         st = MEM && en && sw;
         nd = (rf && st) ? 1 : 0;
         if (rf || st) begin
            if (m_fifo.size() < DEPTH) begin
               r.w[0] = {(rf ? 2'b01 : 2'b10), (m_pend != 16'd0), (rf ? a : 5'd0), m_seq, m_pend};
               r.w[1] = p;
               if (rf) begin r.w[2] = d;  r.w[3] = 32'd0; r.len = 3'd3; end
               else    begin r.w[2] = sa; r.w[3] = sd;    r.len = 3'd4; end
               m_fifo.push_back(r);
               m_seq  = m_seq + 8'd1;
               m_pend = 16'd0;
            end else begin
               nd++;
            end
         end
         for (int k = 0; k < nd; k++) begin
            if (m_pend != 16'hFFFF)  m_pend  = m_pend + 16'd1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
         end
         if (fin) m_act = 1'b0;
         else if (hs) m_idx++;
         if (popm) begin m_cur = nxt; m_act = 1'b1; m_idx = 0; end
      end
      #1;
   endtask

   task automatic rf_cyc(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p, input bit rdy);
      cycle(1'b1, a, d, p, 1'b0, 32'd0, 32'd0, 1'b1, rdy);
   endtask

   task automatic idle_cyc(input bit rdy);
      cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, rdy);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      idle_cyc(1'b1);
      idle_cyc(1'b1);
      rst = 1'b1;
      obs.delete();
   endtask

   function automatic logic [49:0] exp_vec();
      exp_vec = {m_act, (m_act && m_idx == int'(m_cur.len) - 1), (m_act ? m_cur.w[m_idx] : 32'd0), m_drops};
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      idle_cyc(1'b1);
      idle_cyc(1'b1);
      ntests++;
      if ({out_valid, out_last, out_data, drop_cnt} !== 50'd0) begin
         nfail++;
         $display("FAIL reset_state got %h required 0", {out_valid, out_last, out_data, drop_cnt});
      end
      rst = 1'b1;
      obs.delete();
   endtask

   task automatic test_basic();
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h45000000; exp_w[1] = 32'h00400010; exp_w[2] = 32'h00001234;
      apply_reset();
      rf_cyc(5'd5, 32'h00001234, 32'h00400010, 1'b1);
      ntests++;
      if (out_valid !== 1'b0) begin nfail++; $display("FAIL basic_latency_early got %b required 0", out_valid); end
      idle_cyc(1'b1);
      ntests++;
      if (out_valid !== 1'b1 || out_data !== 32'h45000000) begin
         nfail++; $display("FAIL basic_header_time got v=%b d=%h required v=1 d=45000000", out_valid, out_data);
      end
      for (int i = 0; i < 4; i++) begin
         idle_cyc(1'b1);
         ntests++;
         if ({out_valid, out_last, out_data, drop_cnt} !== exp_vec()) begin
            nfail++; $display("FAIL basic_model got %h required %h", {out_valid, out_last, out_data, drop_cnt}, exp_vec());
         end
      end
      ntests++;
      if (obs.size() != 3) begin
         nfail++; $display("FAIL basic_count got %0d required 3", obs.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            ntests++;
            if (obs[i] !== exp_w[i]) begin nfail++; $display("FAIL basic_word%0d got %h required %h", i, obs[i], exp_w[i]); end
         end
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         rf_cyc(5'($urandom_range(1, 31)), $urandom, $urandom, 1'b0);
         ntests++;
         if ({out_valid, out_last, out_data, drop_cnt} !== exp_vec()) begin
            nfail++; $display("FAIL ovf_fill got %h required %h", {out_valid, out_last, out_data, drop_cnt}, exp_vec());
         end
      end
      ntests++;
      if (drop_cnt !== 16'd1) begin nfail++; $display("FAIL ovf_drop_cnt got %0d required 1", drop_cnt); end
      for (int i = 0; i < 30; i++) begin
         idle_cyc(1'b1);
         ntests++;
         if ({out_valid, out_last, out_data, drop_cnt} !== exp_vec()) begin
            nfail++; $display("FAIL ovf_drain got %h required %h", {out_valid, out_last, out_data, drop_cnt}, exp_vec());
         end
      end
      ntests++;
      if (obs.size() != 27) begin
         nfail++; $display("FAIL ovf_words got %0d required 27", obs.size());
      end else begin
         for (int k = 0; k < 9; k++) begin
            ntests++;
            if (obs[3*k][23:16] !== 8'(k)) begin nfail++; $display("FAIL ovf_seq got %0d required %0d", obs[3*k][23:16], k); end
         end
      end
      rf_cyc(5'd9, $urandom, $urandom, 1'b1);
      for (int i = 0; i < 5; i++) idle_cyc(1'b1);
      ntests++;
      if (obs.size() < 28 || obs[27][31:16] !== 16'h6909 || obs[27][15:0] !== 16'h0001) begin
         nfail++; $display("FAIL ovf_pend_hdr got %h required 69090001", (obs.size() > 27) ? obs[27] : 32'hx);
      end
   endtask

   task automatic test_skip_r0();
      apply_reset();
      rf_cyc(5'd0, $urandom, $urandom, 1'b1);
      for (int i = 0; i < 4; i++) begin
         idle_cyc(1'b1);
         ntests++;
         if (out_valid !== 1'b0 || drop_cnt !== 16'd0) begin
            nfail++; $display("FAIL skip_r0_quiet got v=%b drops=%0d required v=0 drops=0", out_valid, drop_cnt);
         end
      end
      rf_cyc(5'd3, $urandom, $urandom, 1'b1);
      idle_cyc(1'b1);
      ntests++;
      if (out_data !== 32'h43000000) begin nfail++; $display("FAIL skip_r0_seq got %h required 43000000", out_data); end
   endtask

   task automatic test_store();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h80000000; exp_w[1] = 32'h00400020; exp_w[2] = 32'h10010004; exp_w[3] = 32'hDEADBEEF;
      apply_reset();
      cycle(1'b0, 5'd0, 32'd0, 32'h00400020, 1'b1, 32'h10010004, 32'hDEADBEEF, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         idle_cyc(1'b1);
         ntests++;
         if ({out_valid, out_last, out_data, drop_cnt} !== exp_vec()) begin
            nfail++; $display("FAIL store_model got %h required %h", {out_valid, out_last, out_data, drop_cnt}, exp_vec());
         end
      end
      ntests++;
      if (obs.size() != (MEM ? 4 : 0)) begin
         nfail++; $display("FAIL store_words got %0d required %0d", obs.size(), MEM ? 4 : 0);
      end else if (MEM) begin
         for (int i = 0; i < 4; i++) begin
            ntests++;
            if (obs[i] !== exp_w[i]) begin nfail++; $display("FAIL store_word%0d got %h required %h", i, obs[i], exp_w[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      apply_reset();
      rf_cyc(5'd7, $urandom, $urandom, 1'b1);
      n = 0;
      while (obs.size() < 2 && n < 10) begin idle_cyc(1'b1); n++; end
      ntests++;
      if (obs.size() < 2) begin nfail++; $display("FAIL rstmid_timeout got %0d words required 2", obs.size()); end
      rst = 1'b0;
      idle_cyc(1'b1);
      ntests++;
      if (out_valid !== 1'b0) begin nfail++; $display("FAIL rstmid_valid got %b required 0", out_valid); end
      rst = 1'b1;
      rf_cyc(5'd2, $urandom, $urandom, 1'b1);
      idle_cyc(1'b1);
      ntests++;
      if (out_valid !== 1'b1 || out_data !== 32'h42000000) begin
         nfail++; $display("FAIL rstmid_hdr got v=%b d=%h required v=1 d=42000000", out_valid, out_data);
      end
   endtask

   task automatic test_seq_wrap();
      apply_reset();
      for (int i = 0; i < 257; i++) begin
         rf_cyc(5'd1, $urandom, $urandom, 1'b1);
         idle_cyc(1'b1);
         idle_cyc(1'b1);
         ntests++;
         if ({out_valid, out_last, out_data, drop_cnt} !== exp_vec()) begin
            nfail++; $display("FAIL wrap_model got %h required %h", {out_valid, out_last, out_data, drop_cnt}, exp_vec());
         end
      end
      for (int i = 0; i < 6; i++) idle_cyc(1'b1);
      ntests++;
      if (drop_cnt !== 16'd0 || obs.size() != 771) begin
         nfail++; $display("FAIL wrap_totals got drops=%0d words=%0d required 0 771", drop_cnt, obs.size());
      end else begin
         for (int k = 0; k < 257; k++) begin
            ntests++;
            if (obs[3*k][23:16] !== 8'(k % 256)) begin
               nfail++; $display("FAIL wrap_seq got %0d required %0d", obs[3*k][23:16], k % 256);
            end
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) == 0, 5'($urandom), $urandom, $urandom,
               $urandom_range(0, 3) == 0, $urandom, $urandom,
               $urandom_range(0, 9) != 0, (i % 400 < 60) ? 1'b0 : ($urandom_range(0, 3) != 0));
         ntests++;
         if ({out_valid, out_last, out_data, drop_cnt} !== exp_vec()) begin
            nfail++; $display("FAIL random_model cyc %0d got %h required %h", i, {out_valid, out_last, out_data, drop_cnt}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_skip_r0();
      test_store();
      test_reset_mid();
      test_seq_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
